shift_result_stage: RTL and testbench
=====================================

// Module: shift_result_stage
// PURPOSE
//  Pipeline stage directly downstream of shifter_16bit: captures shift_out plus destination tag,
//  buffers up to DEPTH results in an in-order skid FIFO with valid/ready handshakes, and commits
//  Z/N condition flags when a result leaves toward the writeback/memory stage.
//  Decouples the combinational shifter from writeback backpressure; in_ready is a registered signal.
// PARAMETERS
//  DATA_W    16  result width (matches shift_out)
//  RID_W     4   destination register id width
//  DEPTH     2   buffer entries, power of two, >=2
// PORTS
//  clk        in   1       single clock, all state on posedge
//  rst_n      in   1       synchronous reset, active-low
//  flush      in   1       drop all buffered entries (branch/exception squash)
//  in_valid   in   1       shifter result valid
//  in_ready   out  1       stage can accept (registered)
//  in_data    in   DATA_W  shift_out from shifter_16bit
//  in_rid     in   RID_W   destination register id
//  in_flag_we in   1       entry updates flags on commit
//  out_valid  out  1       head entry valid
//  out_ready  in   1       downstream accepts head
//  out_data   out  DATA_W  head result
//  out_rid    out  RID_W   head destination id
//  flag_z     out  1       committed zero flag
//  flag_n     out  1       committed negative flag
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): count=0, rd/wr ptr=0, out_valid=0, in_ready=1, flag_z=0, flag_n=0;
//    out_data/out_rid=0. Reset mid-operation discards all entries; flags cleared.
//  - push = in_valid & in_ready; pop = out_valid & out_ready. Latency: pushed data visible on
//    out_* the cycle after push (1 cycle), zero extra latency when empty.
//  - out_valid = (count!=0); out_* show entry at rd ptr; in_ready = (count<DEPTH), registered next-state.
//  - Full: in_ready=0, in_data ignored. Empty: out_valid=0, out_ready ignored.
//  - Simultaneous push+pop (0<count<DEPTH): count unchanged, both ptrs advance, order preserved.
//  - Pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).
//  - Commit: on pop with entry flag_we=1: flag_z <= (out_data==0); flag_n <= out_data[DATA_W-1].
//    flag_we=0 entries leave flags unchanged. Flags never change on push.
//  - flush (priority below rst_n, above push/pop): count=0, ptrs=0, same-cycle push and pop are
//    dropped, flags NOT updated by the dropped pop; in_ready=1 next cycle.
//  - Data is stored verbatim; no arithmetic beyond the zero/sign test.
// CONFIGURATION
//  SHIFT_RESULT_FWD_EN defined: adds ports fwd_valid out [DEPTH], fwd_rid out [DEPTH*RID_W],
//  fwd_data out [DEPTH*DATA_W], one slot per physical entry, valid bit = entry occupied, for
//  decode-stage operand forwarding; combinational from storage, cleared with flush/reset.
//  Undefined: those ports do not exist; core behaviour is identical.
// STRUCTURE
//  Package shift_stage_pkg: DATA_W/RID_W defaults, typedef entry_t {data, rid, flag_we},
//  flag index constants FLAG_Z=0, FLAG_N=1.
//  Sub-module shift_skid_fifo (storage, ptrs, count, in_ready reg); top holds flag register
//  and commit logic.
// TESTING
//  1 rst_n=0 two cycles -> out_valid=0, in_ready=1, flag_z=0, flag_n=0.
//  2 push 0xDD48 (0xBBA9 sll 3) rid=3 flag_we=1, out_ready=1 -> next cycle out_data=0xDD48,
//    out_rid=3; after pop flag_z=0, flag_n=1.
//  3 out_ready=0, push 0xF775, 0x0000, 0x1234 back-to-back -> in_ready=0 after two; 0x1234 held
//    by source; release out_ready -> pops 0xF775, 0x0000, 0x1234 in order.
//  4 commit 0x0000 flag_we=1 -> z=1,n=0; then commit 0x8000 flag_we=0 -> z=1,n=0 unchanged.
//  5 count=2, flush=1 with in_valid=1, out_ready=1 same cycle -> count=0, nothing popped,
//    flags unchanged, in_ready=1 next cycle.
//  6 count=2, rst_n=0 one cycle -> out_valid=0, flags 0; push 0x0001 after -> out_data=0x0001.

Source files
------------

// File: rtl/shift_stage_pkg.sv
// shift_stage_pkg: shared widths, flag bit indices and buffered entry type for the shift result stage.
package shift_stage_pkg;
  localparam int DATA_W = 16;
  localparam int RID_W = 4;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [RID_W-1:0]  rid;
    logic              flag_we;
  } entry_t;
endpackage

// File: rtl/shift_result_stage_if.sv
// shift_result_stage_if: upstream/downstream handshake and flag bundle of the shift result stage.
interface shift_result_stage_if;
  import shift_stage_pkg::*;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [RID_W-1:0]  in_rid;
  logic              in_flag_we;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [RID_W-1:0]  out_rid;
  logic              flag_z;
  logic              flag_n;
  modport master (
    output flush, in_valid, in_data, in_rid, in_flag_we, out_ready,
    input  in_ready, out_valid, out_data, out_rid, flag_z, flag_n
  );
  modport slave (
    input  flush, in_valid, in_data, in_rid, in_flag_we, out_ready,
    output in_ready, out_valid, out_data, out_rid, flag_z, flag_n
  );
endinterface

// File: rtl/shift_skid_fifo.sv
// shift_skid_fifo: in-order DEPTH-entry buffer with registered in_ready and flush.
// SHIFT_RESULT_FWD_EN exposes per-slot occupancy and contents for operand forwarding.
module shift_skid_fifo
  import shift_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   in_valid,
  input  entry_t in_entry,
  output logic   in_ready,
  input  logic   out_ready,
  output logic   out_valid,
  output entry_t head,
  output logic   pop
`ifdef SHIFT_RESULT_FWD_EN
  ,
  output logic   [DEPTH-1:0] fwd_valid,
  output entry_t [DEPTH-1:0] fwd_entry
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic in_ready_q, in_ready_d, push;
  entry_t [DEPTH-1:0] mem_q, mem_d;
  assign out_valid = count_q != '0;
  assign in_ready = in_ready_q;
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;
  // flush squashes the same-cycle push and pop so neither storage nor flags see them
  always_comb begin
    push = in_valid & in_ready_q & ~flush;
    pop = out_valid & out_ready & ~flush;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = in_entry;
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
    in_ready_d = count_d < CW'(DEPTH);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      in_ready_q <= in_ready_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
`ifdef SHIFT_RESULT_FWD_EN
  for (genvar i = 0; i < DEPTH; i++) begin : g_fwd
    logic [PW-1:0] age;
    assign age = PW'(i) - rd_ptr_q;
    assign fwd_valid[i] = {1'b0, age} < count_q;
    assign fwd_entry[i] = fwd_valid[i] ? mem_q[i] : '0;
  end
`endif
endmodule

// File: rtl/shift_result_stage.sv
// shift_result_stage: buffers shifter results and commits Z/N flags as results leave for writeback.
// SHIFT_RESULT_FWD_EN adds fwd_valid/fwd_rid/fwd_data forwarding ports.
module shift_result_stage
  import shift_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  shift_result_stage_if.slave bus
`ifdef SHIFT_RESULT_FWD_EN
  ,
  output logic [DEPTH-1:0]       fwd_valid,
  output logic [DEPTH*RID_W-1:0] fwd_rid,
  output logic [DEPTH*DATA_W-1:0] fwd_data
`endif
);
  entry_t head, in_entry;
  logic pop;
  logic [1:0] flags_q, flags_d;
`ifdef SHIFT_RESULT_FWD_EN
  entry_t [DEPTH-1:0] fwd_entry;
`endif
  assign in_entry = '{data: bus.in_data, rid: bus.in_rid, flag_we: bus.in_flag_we};
  shift_skid_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_entry  (in_entry),
    .in_ready  (bus.in_ready),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .head      (head),
    .pop       (pop)
`ifdef SHIFT_RESULT_FWD_EN
    ,
    .fwd_valid (fwd_valid),
    .fwd_entry (fwd_entry)
`endif
  );
  always_comb begin
    flags_d = flags_q;
    flags_d[FLAG_Z] = (pop & head.flag_we) ? head.data == '0 : flags_q[FLAG_Z];
    flags_d[FLAG_N] = (pop & head.flag_we) ? head.data[DATA_W-1] : flags_q[FLAG_N];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= '0;
    else flags_q <= flags_d;
  end
  assign bus.out_data = head.data;
  assign bus.out_rid = head.rid;
  assign bus.flag_z = flags_q[FLAG_Z];
  assign bus.flag_n = flags_q[FLAG_N];
`ifdef SHIFT_RESULT_FWD_EN
  for (genvar i = 0; i < DEPTH; i++) begin : g_fwd
    assign fwd_rid[i*RID_W +: RID_W] = fwd_entry[i].rid;
    assign fwd_data[i*DATA_W +: DATA_W] = fwd_entry[i].data;
  end
`endif
endmodule

// File: tb/tb_shift_result_stage.sv
// tb_shift_result_stage: directed self-checking bench for shift_result_stage (DEPTH=2).
module tb_shift_result_stage;
  logic clk = 1'b0;
  logic rst_n;
  int n_chk = 0;
  int n_fail = 0;
  shift_result_stage_if bus ();
  shift_result_stage #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] r, input logic we);
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_rid = r;
    bus.in_flag_we = we;
  endtask
  initial begin
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_flag_z", 32'(bus.flag_z), 0);
    chk("rst_flag_n", 32'(bus.flag_n), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 16'hDD48, 4'd3, 1'b1);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    chk("t2_out_valid", 32'(bus.out_valid), 1);
    chk("t2_out_data", 32'(bus.out_data), 32'hDD48);
    chk("t2_out_rid", 32'(bus.out_rid), 3);
    chk("t2_flags_before_pop", 32'({bus.flag_n, bus.flag_z}), 0);
    step();
    chk("t2_flag_z", 32'(bus.flag_z), 0);
    chk("t2_flag_n", 32'(bus.flag_n), 1);
    chk("t2_empty", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hF775, 4'd1, 1'b1);
    step();
    chk("t3_ready_after_one", 32'(bus.in_ready), 1);
    drive(1'b1, 16'h0000, 4'd2, 1'b1);
    step();
    chk("t3_full_ready", 32'(bus.in_ready), 0);
    drive(1'b1, 16'h1234, 4'd4, 1'b1);
    step();
    chk("t3_held_ready", 32'(bus.in_ready), 0);
    chk("t3_head_f775", 32'(bus.out_data), 32'hF775);
    chk("t3_head_rid", 32'(bus.out_rid), 1);
    bus.out_ready = 1'b1;
    step();
    chk("t3_head_0000", 32'(bus.out_data), 32'h0000);
    chk("t3_head_0000_rid", 32'(bus.out_rid), 2);
    chk("t3_flags_f775", 32'({bus.flag_n, bus.flag_z}), 32'b10);
    chk("t3_ready_reopen", 32'(bus.in_ready), 1);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    chk("t3_head_1234", 32'(bus.out_data), 32'h1234);
    chk("t3_head_1234_rid", 32'(bus.out_rid), 4);
    chk("t3_flags_0000", 32'({bus.flag_n, bus.flag_z}), 32'b01);
    step();
    chk("t3_drained", 32'(bus.out_valid), 0);
    chk("t3_flags_1234", 32'({bus.flag_n, bus.flag_z}), 32'b00);
    drive(1'b1, 16'h0000, 4'd5, 1'b1);
    step();
    drive(1'b1, 16'h8000, 4'd6, 1'b0);
    chk("t4_head_zero", 32'(bus.out_data), 0);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    chk("t4_flags_zero", 32'({bus.flag_n, bus.flag_z}), 32'b01);
    chk("t4_head_8000", 32'(bus.out_data), 32'h8000);
    step();
    chk("t4_empty", 32'(bus.out_valid), 0);
    chk("t4_flags_kept", 32'({bus.flag_n, bus.flag_z}), 32'b01);
    bus.out_ready = 1'b0;
    drive(1'b1, 16'hA5A5, 4'd7, 1'b1);
    step();
    drive(1'b1, 16'h5A5A, 4'd8, 1'b1);
    step();
    chk("t5_full", 32'(bus.in_ready), 0);
    chk("t5_valid", 32'(bus.out_valid), 1);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 16'h7777, 4'd9, 1'b1);
    step();
    bus.flush = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    chk("t5_flushed_valid", 32'(bus.out_valid), 0);
    chk("t5_flushed_ready", 32'(bus.in_ready), 1);
    chk("t5_flags_kept", 32'({bus.flag_n, bus.flag_z}), 32'b01);
    step();
    chk("t5_push_dropped", 32'(bus.out_valid), 0);
    bus.out_ready = 1'b0;
    drive(1'b1, 16'h8001, 4'd10, 1'b1);
    step();
    drive(1'b1, 16'h0002, 4'd11, 1'b1);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    chk("t6_full", 32'(bus.in_ready), 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_rst_valid", 32'(bus.out_valid), 0);
    chk("t6_rst_ready", 32'(bus.in_ready), 1);
    chk("t6_rst_flags", 32'({bus.flag_n, bus.flag_z}), 0);
    drive(1'b1, 16'h0001, 4'd12, 1'b1);
    step();
    drive(1'b0, 16'h0, 4'h0, 1'b0);
    chk("t6_out_valid", 32'(bus.out_valid), 1);
    chk("t6_out_data", 32'(bus.out_data), 32'h0001);
    chk("t6_out_rid", 32'(bus.out_rid), 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
